load_store_unit: RTL and testbench

Multi-cycle initiator that services CPU load/store requests against the single-port, word-addressed data memory. It accepts byte, halfword and word accesses over a valid/ready request channel. Sub-word stores are converted into read-modify-write sequences, because the memory only has a word-wide write enable. Results return on a one-cycle response pulse. The block sits between the execute stage and the data memory.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 68 ++++++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane geometry.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts/extends sub-word loads and merges
// sub-word store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        signed_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [15:0] shifted;

  always_comb begin
    shamt = '0;
    case (size_i)
      SZ_BYTE: shamt = {addr_lo_i, 3'b000};
      SZ_HALF: shamt = {addr_lo_i[1], 4'b0000};
      default: shamt = '0;
    endcase
  end

  assign shifted = 16'(rdata_i >> shamt);

  always_comb begin
    load_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: load_o = rdata_i;
    endcase
  end

  // Each byte lane either keeps the read byte or takes the matching store byte.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       sel;
      logic [7:0] src;

      always_comb begin
        sel = 1'b0;
        src = '0;
        case (size_i)
          SZ_BYTE: begin
            sel = (addr_lo_i == LANE);
            src = wdata_i[7:0];
          end
          SZ_HALF: begin
            sel = (addr_lo_i[1] == LANE[1]);
            src = wdata_i[LANE_W*(gi%2) +: LANE_W];
          end
          default: begin
            sel = 1'b1;
            src = wdata_i[LANE_W*gi +: LANE_W];
          end
        endcase
      end

      assign merged_o[LANE_W*gi +: LANE_W] = sel ? src : rdata_i[LANE_W*gi +: LANE_W];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator for a single-port word memory; sub-word
// stores become read-modify-write sequences.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic        mem_WE,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  lsu_state_e  state_q;
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_a_q;
  logic        mem_we_q;
  logic [31:0] mem_wd_q;

  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_A      = mem_a_q;
  assign mem_WE     = mem_we_q;
  assign mem_WD     = mem_wd_q;

  always_comb begin
    req_err = (req_addr[31:2] >= WORD_LIMIT);
    case (req_size)
      SZ_BYTE: req_err = req_err;
      SZ_HALF: req_err = req_err | req_addr[0];
      SZ_WORD: req_err = req_err | (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  lsu_lane_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_lo_q),
    .signed_i  (signed_q),
    .rdata_i   (mem_RD),
    .wdata_i   (wdata_q),
    .load_o    (load_val),
    .merged_o  (merged)
  );

  // Memory-side outputs are registered so that reset clears mem_WE at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= SZ_BYTE;
      addr_lo_q    <= 2'b00;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_a_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            signed_q  <= req_signed;
            size_q    <= req_size;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we && (req_size == SZ_WORD)) begin
              state_q  <= WRITE;
              mem_a_q  <= {2'b00, req_addr[31:2]};
              mem_we_q <= 1'b1;
              mem_wd_q <= req_wdata;
            end else begin
              state_q <= READ;
              mem_a_q <= {2'b00, req_addr[31:2]};
            end
          end
        end
        READ: begin
          if (we_q) begin
            state_q  <= WRITE;
            mem_we_q <= 1'b1;
            mem_wd_q <= merged;
          end else begin
            state_q      <= RESP;
            mem_a_q      <= '0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_val;
          end
        end
        WRITE: begin
          state_q      <= RESP;
          mem_a_q      <= '0;
          mem_we_q     <= 1'b0;
          mem_wd_q     <= '0;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against an arithmetic memory model.
module tb_load_store_unit;

  localparam int MW = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_WE     (mem_WE),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD)
  );

  // Behavioural memory and the bench's own expectation of its contents.
  logic [31:0] mem   [0:MW-1] = '{default: 32'd0};
  logic [31:0] model [0:MW-1] = '{default: 32'd0};
  int          we_cycles = 0;
  logic [31:0] wr_a = '0;
  logic [31:0] wr_d = '0;

  assign mem_RD = (mem_A < 32'(MW)) ? mem[mem_A[2:0]] : 32'd0;

  always @(posedge clk) begin
    if (mem_WE) begin
      we_cycles++;
      wr_a <= mem_A;
      wr_d <= mem_WD;
      if (mem_A < 32'(MW)) mem[mem_A[2:0]] <= mem_WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] shift;
    if (sz == 2'd0) begin
      shift = 8 * off;
      mask  = 32'hFF << shift;
    end else if (sz == 2'd1) begin
      shift = 16 * off[1];
      mask  = 32'hFFFF << shift;
    end else begin
      shift = 0;
      mask  = 32'hFFFF_FFFF;
    end
    return (old & ~mask) | ((wd << shift) & mask);
  endfunction

  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd);
    logic [29:0] idx;
    logic [1:0]  off;
    logic        err;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    int          exp_lat;
    int          n;
    int          w0;
    idx = addr[31:2];
    off = addr[1:0];
    err = (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0)
          || (idx >= 30'(MW));
    exp_rd   = 32'd0;
    exp_word = 32'd0;
    if (err)                    exp_lat = 1;
    else if (!we || sz == 2'd2) exp_lat = 2;
    else                        exp_lat = 3;
    if (!err && !we) exp_rd = model_load(model[idx], sz, off, sg);
    if (!err && we)  exp_word = model_store(model[idx], wd, sz, off);

    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    w0 = we_cycles;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".err"}, resp_err, err);
    chk({tag, ".we_cycles"}, we_cycles - w0, (!err && we) ? 1 : 0);
    @(negedge clk);
    chk({tag, ".pulse"}, resp_valid, 1'b0);
    if (!err && we) begin
      chk({tag, ".wr_addr"}, wr_a, {2'b00, idx});
      chk({tag, ".wr_data"}, wr_d, exp_word);
      model[idx] = exp_word;
      chk({tag, ".mem"}, mem[idx], exp_word);
    end
    $display("txn %s we=%0d sz=%0d sg=%0d addr=%h wd=%h -> err=%0d rdata=%h lat=%0d",
             tag, we, sz, sg, addr, wd, resp_err, resp_rdata, n);
  endtask

  initial begin
    int          w0;
    int          acc;
    int          nresp;
    int          cyc;
    int          last;
    logic        pend;
    logic [1:0]  sz;
    logic [31:0] addr;

    // Reset state
    #2;
    chk("rst.ready", req_ready, 1'b0);
    chk("rst.resp_valid", resp_valid, 1'b0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.err", resp_err, 1'b0);
    chk("rst.mem_A", mem_A, 32'd0);
    chk("rst.mem_WE", mem_WE, 1'b0);
    chk("rst.mem_WD", mem_WD, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst.ready_after", req_ready, 1'b1);

    // Word round trip, RMW byte store, signed/unsigned sub-word loads
    txn("sw8", 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    txn("lw8", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    txn("sw4", 1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344);
    txn("sb6", 1'b1, 2'd0, 1'b0, 32'h6, 32'h000000AA);
    chk("sb6.word", mem[1], 32'h11AA3344);
    txn("sw0", 1'b1, 2'd2, 1'b0, 32'h0, 32'h80FF7F01);
    txn("lb2", 1'b0, 2'd0, 1'b1, 32'h2, 32'h0);
    txn("lbu3", 1'b0, 2'd0, 1'b0, 32'h3, 32'h0);
    txn("lh2", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0);
    txn("lhu0", 1'b0, 2'd1, 1'b0, 32'h0, 32'h0);
    txn("sh2", 1'b1, 2'd1, 1'b0, 32'hE, 32'h0000BEEF);

    // Error cases
    txn("err_lw2", 1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
    txn("err_sw14", 1'b1, 2'd2, 1'b0, 32'h14, 32'h12345678);
    txn("err_sz3", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    txn("err_sh1", 1'b1, 2'd1, 1'b0, 32'h1, 32'hFFFF);

    // Reset during the WRITE cycle of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h5; req_wdata = 32'h55;
    w0 = we_cycles;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid.we_before", mem_WE, 1'b1);
    reset = 1'b1;
    #1 chk("rstmid.we_drop", mem_WE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid.no_resp", resp_valid, 1'b0);
      chk("rstmid.ready_low", req_ready, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid.no_resp_after", resp_valid, 1'b0);
    end
    chk("rstmid.we_cycles", we_cycles - w0, 0);
    chk("rstmid.mem", mem[1], model[1]);
    chk("rstmid.ready", req_ready, 1'b1);
    $display("txn rstmid sb addr=00000005 dropped mem[1]=%h", mem[1]);

    // Back-to-back word loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h0;
    pend  = req_ready;
    acc   = 0;
    nresp = 0;
    cyc   = 0;
    last  = 0;
    for (int c = 0; c < 40 && nresp < 3; c++) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        acc++;
        if (acc < 3) req_addr = 32'(acc * 4);
        else req_valid = 1'b0;
      end
      if (resp_valid) begin
        chk("b2b.rdata", resp_rdata, model[nresp]);
        if (nresp > 0) chk("b2b.gap", cyc - last, 3);
        $display("txn b2b lw addr=%h rdata=%h cycle=%0d", nresp * 4, resp_rdata, cyc);
        last = cyc;
        nresp++;
      end
      pend = req_valid && req_ready;
    end
    req_valid = 1'b0;
    chk("b2b.count", nresp, 3);
    chk("b2b.accepted", acc, 3);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 23));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) addr = addr & ~32'd1;
        if (sz == 2'd2) addr = addr & ~32'd3;
      end
      txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
          addr, $urandom);
    end
    for (int i = 0; i < MW; i++) chk($sformatf("final.mem%0d", i), mem[i], model[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
